dice_match_ctrl: RTL
====================

# dice_match_ctrl

Match controller that sequences the `dice` coin-flip FSM for a two-player game. It pulses the dice `start`, feeds three coin bits per roll from an internal LFSR or from forced test bits, samples the resulting colour, and keeps score. It sits between the top-level game UI (`go`, score display) and a single `dice` instance, which it owns exclusively.

## Interface
- `WIN_SCORE`, default 3: points needed to win; 1..2^SCORE_W-1.
- `MAX_RETRY`, default 2: NONE results tolerated per turn before the turn passes.
- `SCORE_W`, default 4: score counter width.
- `LFSR_SEED`, default 8'hA5: LFSR reset value. 8'h00 is replaced by 8'h01.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `go` in 1: start a match; honoured only in IDLE or DONE.
- `force_en` in 1: sampled in START; if 1, this roll uses `force_bits` instead of the LFSR.
- `force_bits` in 3: forced coins; bit2 goes out in C0, bit1 in C1, bit0 in C2.
- `dice_out` in 2: dice colour; 01 RED, 10 BLUE, 00 NONE, 11 treated as NONE.
- `dice_start` out 1: to dice `start`.
- `dice_coin` out 1: to dice `coin`.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: level, high in DONE.
- `winner` out 1: 0 = player A, 1 = player B; valid while `done`.
- `turn` out 1: current roller; 0 = A.
- `score_a`, `score_b` out SCORE_W: scores.
- `roll_valid` out 1: one-cycle pulse in SAMPLE.
- `roll_color` out 2: normalised `dice_out` (11 becomes 00); valid with `roll_valid`.

## Operation
- States: IDLE, START, C0, C1, C2, WAIT, SAMPLE, DONE.
- IDLE/DONE → START on `go`. On entry, clear scores, `turn`, and `retry_cnt`.
- START: `dice_start`=1. Latch the coin source (`force_en`/`force_bits`). Go to C0.
- C0, C1, C2: `dice_start`=0. `dice_coin` = the selected bit. The LFSR advances one step per C cycle only when not forced.
- WAIT: `dice_coin`=0. During this cycle the dice is in its leaf state and registers the colour.
- SAMPLE: `roll_valid`=1. Evaluate `dice_out`:
  - RED: current player +1, clear `retry_cnt`, toggle `turn`.
  - BLUE: opponent +1, clear `retry_cnt`, toggle `turn`.
  - NONE: if `retry_cnt` < MAX_RETRY, increment it and keep `turn`. Otherwise clear it and toggle `turn` with no score change.
- After SAMPLE, go to DONE if the updated score equals WIN_SCORE (set `winner` to that player); otherwise go to START.
- Coin-to-colour map: 001 RED, 000 NONE, 011 BLUE, 010 NONE, 101 NONE, 100 BLUE, 111 NONE, 110 RED.
- `dice_out` is ignored outside SAMPLE, because the dice colour register has no reset.
- `go` while busy is ignored. Scores saturate at WIN_SCORE and never wrap.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1, output bit 0. It is loaded only at reset, so successive matches differ.

## Timing
- Reset values: state IDLE, all outputs 0, LFSR = seed. A reset mid-roll aborts immediately, and the dice is also reset.
- One roll is 6 cycles, START through SAMPLE. Back-to-back rolls have no idle cycle between SAMPLE and the next START.
- `dice_start` is high for exactly one cycle per roll. `dice_coin` is registered.
- `go` in DONE re-enters START on the next edge, with scores cleared in the same edge.
- Scores, `turn`, and `done`/`winner` update on the edge that leaves SAMPLE.

## Structure
- Package `dice_pkg`: colour codes NONE/RED/BLUE and the controller state enum. The `dice` block's parameters migrate here.
- Sub-module `dice_coin_lfsr`: ports `clk`, `rst`, `adv`, `bit_out`; parameter SEED.
- The controller does not instantiate `dice`; the top level connects them.

## Test plan
- Forced 001 at match start, player A → SAMPLE 6 cycles after `go`: `roll_color`=01, `score_a`=1, `turn`=1.
- Forced 100 on A's turn → `roll_color`=10, `score_b`=1, `score_a`=0, `turn`=1.
- Forced 000 three times, MAX_RETRY=2 → first two NONEs keep `turn`=0; the third toggles `turn` to 1, scores stay 0.
- WIN_SCORE=3, forced RED ×5 → scores reach A=3, B=2, then `done`=1, `winner`=0, `busy`=0. `go` then clears scores.
- Assert `rst` low during C1 → all outputs 0 asynchronously. The next `go` performs a full 6-cycle roll.
- `go` pulsed during C2 → ignored: scores, state, and LFSR sequence unchanged.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared definitions for the dice game: colour codes, coin count per roll,
// the match controller state encoding and colour normalisation.
package dice_pkg;

    // Coins fed to the dice per roll.
    localparam int COIN_BITS = 3;

    // Dice colour codes; 2'b11 is not a legal dice output and reads as NONE.
    typedef enum logic [1:0] {
        COL_NONE = 2'b00,
        COL_RED  = 2'b01,
        COL_BLUE = 2'b10
    } color_e;

    // Match controller states, one roll is START through SAMPLE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_C0,
        ST_C1,
        ST_C2,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // Fold the unused code 11 onto NONE so downstream logic sees three colours.
    function automatic logic [1:0] norm_color(input logic [1:0] raw);
        return (raw == 2'b11) ? 2'b00 : raw;
    endfunction

endpackage

// File: rtl/dice_coin_lfsr.sv
// 8-bit Fibonacci LFSR supplying pseudo-random coin bits to the dice.
// Loaded only at reset so consecutive matches see different coin sequences.
module dice_coin_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic bit_out
);

    // An all-zero state would lock up the register, so a zero seed becomes 1.
    localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] state;

    // Shift right one step per advance; feedback taps realise x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst) begin
            state <= INIT;
        end else if (adv) begin
            state <= {state[0] ^ state[2] ^ state[3] ^ state[4], state[7:1]};
        end
    end

    assign bit_out = state[0];

endmodule

// File: rtl/dice_match_ctrl.sv
// Two-player match controller: drives the dice start/coin pins, samples the
// resulting colour, keeps score and declares a winner.
module dice_match_ctrl
    import dice_pkg::*;
#(
    parameter int         WIN_SCORE = 3,
    parameter int         MAX_RETRY = 2,
    parameter int         SCORE_W   = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               force_en,
    input  logic [2:0]         force_bits,
    input  logic [1:0]         dice_out,
    output logic               dice_start,
    output logic               dice_coin,
    output logic               busy,
    output logic               done,
    output logic               winner,
    output logic               turn,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               roll_valid,
    output logic [1:0]         roll_color
);

    localparam int                 RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_e               state;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 force_q;
    logic [2:0]           fbits_q;
    logic                 lfsr_adv;
    logic                 lfsr_bit;
    logic                 a_pt;
    logic                 b_pt;
    logic                 win_a;
    logic                 win_b;
    logic [SCORE_W-1:0]   score_a_nxt;
    logic [SCORE_W-1:0]   score_b_nxt;

    dice_coin_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv     (lfsr_adv),
        .bit_out (lfsr_bit)
    );

    // The dice colour register has no reset, so dice_out is only trusted in SAMPLE.
    assign roll_color = roll_valid ? norm_color(dice_out) : 2'b00;

    // Step the LFSR on each edge that loads a coin, unless this roll is forced.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        lfsr_adv = 1'b0;
        case (state)
            ST_START:     lfsr_adv = !force_en;
            ST_C0, ST_C1: lfsr_adv = !force_q;
            default:      lfsr_adv = 1'b0;
        endcase
    end

    // Score the sampled colour: RED favours the roller, BLUE the opponent.
    always_comb begin
        a_pt        = ((roll_color == COL_RED)  && !turn) || ((roll_color == COL_BLUE) && turn);
        b_pt        = ((roll_color == COL_BLUE) && !turn) || ((roll_color == COL_RED)  && turn);
        score_a_nxt = (a_pt && (score_a != WIN)) ? score_a + SCORE_W'(1) : score_a;
        score_b_nxt = (b_pt && (score_b != WIN)) ? score_b + SCORE_W'(1) : score_b;
        win_a       = a_pt && (score_a_nxt == WIN);
        win_b       = b_pt && (score_b_nxt == WIN);
    end

    // Match sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            dice_start <= 1'b0;
            dice_coin  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner     <= 1'b0;
            turn       <= 1'b0;
            score_a    <= '0;
            score_b    <= '0;
            roll_valid <= 1'b0;
            retry_cnt  <= '0;
            force_q    <= 1'b0;
            fbits_q    <= 3'b000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state      <= ST_START;
                        dice_start <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        winner     <= 1'b0;
                        turn       <= 1'b0;
                        score_a    <= '0;
                        score_b    <= '0;
                        retry_cnt  <= '0;
                    end
                end
                ST_START: begin
                    dice_start <= 1'b0;
                    force_q    <= force_en;
                    fbits_q    <= force_bits;
                    dice_coin  <= force_en ? force_bits[2] : lfsr_bit;
                    state      <= ST_C0;
                end
                ST_C0: begin
                    dice_coin <= force_q ? fbits_q[1] : lfsr_bit;
                    state     <= ST_C1;
                end
                ST_C1: begin
                    dice_coin <= force_q ? fbits_q[0] : lfsr_bit;
                    state     <= ST_C2;
                end
                ST_C2: begin
                    dice_coin <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    roll_valid <= 1'b1;
                    state      <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    roll_valid <= 1'b0;
                    score_a    <= score_a_nxt;
                    score_b    <= score_b_nxt;
                    if (a_pt || b_pt) begin
                        retry_cnt <= '0;
                        turn      <= ~turn;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end else begin
                        retry_cnt <= '0;
                        turn      <= ~turn;
                    end
                    if (win_a || win_b) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        winner <= win_b;
                    end else begin
                        state      <= ST_START;
                        dice_start <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
